// File: rtl/h80cpu_uart_rx_io_if.sv
// H80 bus control signals shared by the UART RX I/O slave; data stays a plain inout port on the slave.
interface h80cpu_uart_rx_io_if #(
  parameter int BUS_ADDR_WIDTH = 16,
  parameter int BUS_CMD_WIDTH  = 3
);
  logic                      ce_n;
  logic [BUS_ADDR_WIDTH-1:0] addr;
  logic [BUS_CMD_WIDTH-1:0]  cmd;
  logic                      wait_n;

  modport master (output ce_n, output addr, output cmd, input wait_n);
  modport slave  (input ce_n, input addr, input cmd, output wait_n);
endinterface

// File: rtl/h80cpu_uart_rx_io.sv
// H80 bus slave returning 8N1 bytes from uart_rxp; bytes land at mid-stop-bit, RXDATA reads stall (wait_n=0) while empty.
// H80_UART_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO; otherwise a single holding register buffers the byte.
module h80cpu_uart_rx_io #(
  parameter int BUS_ADDR_WIDTH = 16,
  parameter int BUS_CMD_WIDTH  = 3,
  parameter int BUS_DATA_WIDTH = 16,
  parameter int CLK_FREQ       = 50000000,
  parameter int UART_FREQ      = 115200,
  parameter int FIFO_DEPTH     = 16,
  parameter logic [BUS_CMD_WIDTH-1:0] BUS_CMD_READ  = BUS_CMD_WIDTH'(1),
  parameter logic [BUS_CMD_WIDTH-1:0] BUS_CMD_WRITE = BUS_CMD_WIDTH'(2)
) (
  input  logic                      clk,
  input  logic                      reset,
  h80cpu_uart_rx_io_if.slave        bus,
  inout  wire  [BUS_DATA_WIDTH-1:0] data,
  input  logic                      uart_rxp,
  output logic                      rx_irq
);
  localparam int BIT_CYCLES = CLK_FREQ / UART_FREQ;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CW         = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(BIT_CYCLES);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_DATA = '0;
  localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_STAT = BUS_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          rx_s1, rx_s2, armed;
  logic          push, ferr_evt, expire;

  // counter is loaded with the interval and fires when it reaches 1
  assign expire = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1   <= 1'b0;
      rx_s2   <= 1'b0;
      armed   <= 1'b0;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_s1   <= uart_rxp;
      rx_s2   <= rx_s1;
      if (rx_s2) armed <= 1'b1;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    push        = 1'b0;
    ferr_evt    = 1'b0;
    if (state != IDLE && !expire) cnt_nxt = cnt - 1'b1;
    unique case (state)
      IDLE: if (armed && !rx_s2) begin
        cnt_nxt   = CNT_HALF;
        state_nxt = START;
      end
      START: if (expire) begin
        if (rx_s2) begin
          state_nxt = IDLE;
        end else begin
          state_nxt   = DATA;
          cnt_nxt     = CNT_BIT;
          bit_idx_nxt = '0;
        end
      end
      DATA: if (expire) begin
        shreg_nxt   = {rx_s2, shreg[7:1]};
        cnt_nxt     = CNT_BIT;
        bit_idx_nxt = bit_idx + 1'b1;
        if (bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP: if (expire) begin
        push      = rx_s2;
        ferr_evt  = !rx_s2;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic       empty, full, pop, wr_en, ovr_evt;
  logic [7:0] head;

  // a pop in the same cycle frees the slot, so a push into a full buffer still lands
  assign wr_en   = push && (!full || pop);
  assign ovr_evt = push && full && !pop;

`ifdef H80_UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (pop)   rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp[AW-1:0]] <= shreg;
  end
`else
  logic [7:0] hold;
  logic       hold_vld;

  assign empty = !hold_vld;
  assign full  = hold_vld;
  assign head  = hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold     <= '0;
      hold_vld <= 1'b0;
    end else if (wr_en) begin
      hold     <= shreg;
      hold_vld <= 1'b1;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end
`endif

  logic                      sel, rd_data, rd_stat, wr_stat, ovr, ferr;
  logic [BUS_DATA_WIDTH-1:0] rd_val;

  assign sel     = !bus.ce_n && !reset;
  assign rd_data = sel && (bus.cmd == BUS_CMD_READ)  && (bus.addr == ADDR_DATA);
  assign rd_stat = sel && (bus.cmd == BUS_CMD_READ)  && (bus.addr == ADDR_STAT);
  assign wr_stat = sel && (bus.cmd == BUS_CMD_WRITE) && (bus.addr == ADDR_STAT);

  assign bus.wait_n = !(rd_data && empty);
  assign pop        = rd_data && !empty;
  assign rd_val     = rd_data ? BUS_DATA_WIDTH'(head)
                              : BUS_DATA_WIDTH'({5'b0, ferr, ovr, !empty});
  assign data       = (rd_data || rd_stat) ? rd_val : {BUS_DATA_WIDTH{1'bz}};

  // set beats write-1-to-clear when both land in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr    <= 1'b0;
      ferr   <= 1'b0;
      rx_irq <= 1'b0;
    end else begin
      ovr    <= ovr_evt  || (ovr  && !(wr_stat && data[1]));
      ferr   <= ferr_evt || (ferr && !(wr_stat && data[2]));
      rx_irq <= !empty;
    end
  end
endmodule

// File: tb/tb_h80cpu_uart_rx_io.sv
`timescale 1ns/1ps
module tb_h80cpu_uart_rx_io;
  localparam int BITC = 10;
`ifdef H80_UART_RX_FIFO_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [2:0] RD = 3'b001;
  localparam logic [2:0] WR = 3'b010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rxp = 1'b1;
  logic        rx_irq;
  logic [15:0] drv = '0;
  logic        drv_en = 1'b0;
  wire  [15:0] data;
  assign data = drv_en ? drv : 16'hzzzz;

  h80cpu_uart_rx_io_if bus ();

  h80cpu_uart_rx_io #(
    .CLK_FREQ (1000000),
    .UART_FREQ(100000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .data    (data),
    .uart_rxp(uart_rxp),
    .rx_irq  (rx_irq)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  byte unsigned q[$];
  bit          m_ovr = 1'b0;
  bit          m_ferr = 1'b0;
  bit          busy = 1'b1;
  bit          bus_chk = 1'b0;

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] m_status();
    return {13'b0, m_ferr, m_ovr, q.size() != 0};
  endfunction

  // single compare process: model vs DUT, away from the active edge
  always @(negedge clk) begin
    #2;
    if (!busy) chk("rx_irq", {15'b0, rx_irq}, {15'b0, q.size() != 0});
    if (bus_chk) begin
      if (bus.addr == 16'h0000) begin
        chk("rxdata_wait_n", {15'b0, bus.wait_n}, {15'b0, q.size() != 0});
        if (q.size() != 0) chk("rxdata", data, {8'h00, q[0]});
      end else begin
        chk("status_wait_n", {15'b0, bus.wait_n}, 16'h0001);
        chk("status", data, m_status());
      end
    end else if (bus.ce_n || bus.cmd != RD) begin
      chk("idle_wait_n", {15'b0, bus.wait_n}, 16'h0001);
    end
  end

  task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
    busy = 1'b1;
    @(negedge clk);
    bus.ce_n = 1'b0; bus.cmd = RD; bus.addr = a; bus_chk = 1'b1;
    #1 v = data;
    @(posedge clk);
    if (a == 16'h0000 && q.size() != 0) void'(q.pop_front());
    @(negedge clk);
    bus.ce_n = 1'b1; bus.cmd = '0; bus_chk = 1'b0;
    @(negedge clk);
    busy = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] v);
    busy = 1'b1;
    @(negedge clk);
    bus.ce_n = 1'b0; bus.cmd = WR; bus.addr = a; drv = v; drv_en = 1'b1;
    @(posedge clk);
    if (a == 16'h0001) begin
      if (v[1]) m_ovr = 1'b0;
      if (v[2]) m_ferr = 1'b0;
    end
    @(negedge clk);
    bus.ce_n = 1'b1; bus.cmd = '0; drv_en = 1'b0;
    @(negedge clk);
    busy = 1'b0;
  endtask

  task automatic send_frame(input byte unsigned b, input bit stop_ok, input bit mdl);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rxp = f[i];
      repeat (BITC - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rxp = 1'b1;
    repeat (3) @(negedge clk);
    if (mdl) begin
      if (!stop_ok) m_ferr = 1'b1;
      else if (q.size() == DEPTH) m_ovr = 1'b1;
      else q.push_back(b);
    end
    @(negedge clk);
    busy = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    int          cyc;
    logic [9:0]  f;
    bus.ce_n = 1'b1; bus.cmd = '0; bus.addr = '0;

    repeat (3) @(negedge clk);
    #2;
    chk("reset_wait_n", {15'b0, bus.wait_n}, 16'h0001);
    chk("reset_rx_irq", {15'b0, rx_irq}, 16'h0000);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    busy = 1'b0;

    // basic frame, read, status
    send_frame(8'h5A, 1'b1, 1'b1);
    bus_read(16'h0000, v);  chk("read_5a", v, 16'h005A);
    bus_read(16'h0001, v);  chk("status_after_pop", v, 16'h0000);
    #2 chk("rx_irq_after_pop", {15'b0, rx_irq}, 16'h0000);

    // read while empty stalls until the byte arrives
    busy = 1'b1;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        @(negedge clk);
        bus.ce_n = 1'b0; bus.cmd = RD; bus.addr = 16'h0000;
        #1 cyc = 0;
        while (!bus.wait_n && cyc < 300) begin
          @(negedge clk); #1; cyc++;
        end
        chk("stall_long_enough", {15'b0, cyc >= 80 && cyc < 300}, 16'h0001);
        v = data;
        chk("stall_read_a5", v, 16'h00A5);
        @(posedge clk);
        @(negedge clk);
        bus.ce_n = 1'b1; bus.cmd = '0;
      end
    join
    repeat (2) @(negedge clk);
    busy = 1'b0;
    bus_read(16'h0001, v);  chk("status_after_stall", v, 16'h0000);

    // overflow
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b1, 1'b1);
    bus_read(16'h0001, v);  chk("status_overflow", v, 16'h0003);
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(16'h0000, v);  chk("overflow_read", v, 16'(i));
    end
    bus_read(16'h0001, v);  chk("status_ovr_only", v, 16'h0002);
    bus_write(16'h0001, 16'h0002);
    bus_read(16'h0001, v);  chk("status_ovr_clr", v, 16'h0000);

    // framing error
    send_frame(8'h77, 1'b0, 1'b1);
    bus_read(16'h0001, v);  chk("status_ferr", v, 16'h0004);
    bus_write(16'h0001, 16'h0004);
    bus_read(16'h0001, v);  chk("status_ferr_clr", v, 16'h0000);

    // short glitch
    busy = 1'b1;
    @(negedge clk); uart_rxp = 1'b0;
    repeat (3) @(negedge clk); uart_rxp = 1'b1;
    repeat (30) @(negedge clk);
    busy = 1'b0;
    repeat (3) @(negedge clk);
    bus_read(16'h0001, v);  chk("status_glitch", v, 16'h0000);

    // reset in the middle of data bit 4
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    bus_read(16'h0001, v);  chk("status_pre_reset", v, 16'h0005);
    busy = 1'b1;
    f = {1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rxp = f[i];
      if (i == 5) begin
        repeat (4) @(negedge clk);
        reset = 1'b1;
        q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (BITC - 7) @(negedge clk);
      end else begin
        repeat (BITC - 1) @(negedge clk);
      end
    end
    repeat (4) @(negedge clk);
    busy = 1'b0;
    #2 chk("rx_irq_post_reset", {15'b0, rx_irq}, 16'h0000);
    bus_read(16'h0001, v);  chk("status_post_reset", v, 16'h0000);
    send_frame(8'h3C, 1'b1, 1'b1);
    bus_read(16'h0000, v);  chk("read_3c", v, 16'h003C);

    // randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: send_frame(8'($urandom), $urandom_range(0, 7) != 0, 1'b1);
        1: bus_read((q.size() != 0) ? 16'h0000 : 16'h0001, v);
        2: bus_read(16'h0001, v);
        default: bus_write(16'h0001, 16'($urandom_range(0, 3) << 1));
      endcase
    end
    while (q.size() != 0) bus_read(16'h0000, v);
    bus_read(16'h0001, v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
